// File: rtl/ltc2333_write.sv
// rtl/ltc2333_write.sv - LTC2333 conversion/control-word write sequencer (CNV, SCKI, SDI).
// Optional macro LTC2333_WRITE_BUSY_SYNC_EN: 2-flop synchronizer on busy instead of a single flop.
module ltc2333_write #(
  parameter int          BUSY_SIGNAL  = 0,
  parameter int          BUSY_TIME    = 550,
  parameter int          CLOCK_PERIOD = 20,
  parameter int          N_CH         = 8,
  parameter logic [2:0]  SOFTSPAN     = 3'b111
) (
  input  logic clk,
  input  logic aresetn,
  input  logic busy,
  output logic cnv,
  output logic scki,
  output logic sdi
);

  localparam int BUSY_CYCLES = (BUSY_TIME + CLOCK_PERIOD - 1) / CLOCK_PERIOD;
  // WAIT begins on frame cycle 2, so its last cycle is cnt = BUSY_CYCLES-3
  localparam int WAIT_LAST   = (BUSY_CYCLES > 3) ? (BUSY_CYCLES - 3) : 0;
  localparam logic [2:0] CH_LAST = 3'(N_CH - 1);

  typedef enum logic [2:0] {S_RESET, S_CNV_HI, S_WAIT, S_SHIFT, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [2:0]  ch_q, ch_d;
  logic        cnv_d, scki_d, sdi_d;
  logic [7:0]  ctrl;
  logic        busy_r;
  logic        wait_done;

`ifdef LTC2333_WRITE_BUSY_SYNC_EN
  logic busy_s1;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      busy_s1 <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      busy_s1 <= busy;
      busy_r  <= busy_s1;
    end
  end
`else
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) busy_r <= 1'b0;
    else          busy_r <= busy;
  end
`endif

  assign ctrl    = {1'b1, 1'b0, ch_q, SOFTSPAN};
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    if (BUSY_SIGNAL != 0) wait_done = (cnt_q >= 16'd1) && !busy_r;
    else                  wait_done = (cnt_q >= 16'(WAIT_LAST));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    ch_d    = ch_q;
    cnv_d   = 1'b0;
    scki_d  = 1'b0;
    sdi_d   = sdi;
    case (state_q)
      S_RESET: begin
        state_d = S_CNV_HI;
        cnt_d   = 16'd0;
        cnv_d   = 1'b1;
        sdi_d   = 1'b0;
      end
      S_CNV_HI: begin
        sdi_d = 1'b0;
        if (cnt_q == 16'd1) begin
          state_d = S_WAIT;
          cnt_d   = 16'd0;
        end else begin
          cnv_d = 1'b1;
        end
      end
      S_WAIT: begin
        // saturate so a stuck busy cannot wrap the counter
        if (cnt_q == 16'hffff) cnt_d = cnt_q;
        if (wait_done) begin
          state_d = S_SHIFT;
          cnt_d   = 16'd0;
          sdi_d   = ctrl[7];
        end
      end
      S_SHIFT: begin
        if (cnt_q == 16'd47) begin
          state_d = S_GAP;
          cnt_d   = 16'd0;
          sdi_d   = 1'b0;
          ch_d    = (ch_q == CH_LAST) ? 3'd0 : ch_q + 3'd1;
        end else begin
          scki_d = cnt_inc[0];
          // new data only on even k, i.e. while scki is low
          if (!cnt_inc[0]) sdi_d = (cnt_inc < 16'd16) ? ctrl[~cnt_inc[3:1]] : 1'b0;
        end
      end
      S_GAP: begin
        sdi_d = 1'b0;
        if (cnt_q == 16'd1) begin
          state_d = S_CNV_HI;
          cnt_d   = 16'd0;
          cnv_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = 16'd0;
        sdi_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_RESET;
      cnt_q   <= 16'd0;
      ch_q    <= 3'd0;
      cnv     <= 1'b0;
      scki    <= 1'b0;
      sdi     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      cnv     <= cnv_d;
      scki    <= scki_d;
      sdi     <= sdi_d;
    end
  end

endmodule

// File: tb/tb_ltc2333_write.sv
// tb/tb_ltc2333_write.sv - self-checking bench for ltc2333_write (default, N_CH=3, BUSY_SIGNAL=1).
module tb_ltc2333_write;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       busy2;
  logic [2:0] cnv, scki, sdi;

  always #10 clk = ~clk;

  ltc2333_write u0 (.clk(clk), .aresetn(aresetn), .busy(1'b0), .cnv(cnv[0]), .scki(scki[0]), .sdi(sdi[0]));
  ltc2333_write #(.N_CH(3), .SOFTSPAN(3'b011)) u1 (
    .clk(clk), .aresetn(aresetn), .busy(1'b0), .cnv(cnv[1]), .scki(scki[1]), .sdi(sdi[1]));
  ltc2333_write #(.BUSY_SIGNAL(1)) u2 (
    .clk(clk), .aresetn(aresetn), .busy(busy2), .cnv(cnv[2]), .scki(scki[2]), .sdi(sdi[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // frame monitor: collects the 24 sdi bits sampled on scki rises of each frame
  int         cyc[3]      = '{default:0};
  int         nrise[3]    = '{default:0};
  int         first[3]    = '{default:0};
  int         nrec[3]     = '{default:0};
  int         viol[3]     = '{default:0};
  logic [23:0] word[3]    = '{default:0};
  logic       started[3]  = '{default:0};
  logic       pc[3]       = '{default:0};
  logic       ps[3]       = '{default:0};
  logic [23:0] rec_word[3][16];
  int         rec_n[3][16];
  int         rec_first[3][16];
  int         rec_per[3][16];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!aresetn) begin
        nrise[i] <= 0; word[i] <= '0; started[i] <= 1'b0;
        pc[i] <= 1'b0; ps[i] <= 1'b0; cyc[i] <= 0;
      end else begin
        pc[i] <= cnv[i];
        ps[i] <= scki[i];
        if (cnv[i] && !pc[i]) begin
          if (nrise[i] > 0 && started[i] && nrec[i] < 16) begin
            rec_word[i][nrec[i]]  <= word[i];
            rec_n[i][nrec[i]]     <= nrise[i];
            rec_first[i][nrec[i]] <= first[i];
            rec_per[i][nrec[i]]   <= cyc[i] + 1;
            nrec[i] <= nrec[i] + 1;
          end
          cyc[i] <= 0; nrise[i] <= 0; word[i] <= '0; started[i] <= 1'b1;
        end else begin
          cyc[i] <= cyc[i] + 1;
        end
        if (scki[i] && !ps[i]) begin
          if (cnv[i] || (i == 2 && busy2)) viol[i] <= viol[i] + 1;
          word[i] <= {word[i][22:0], sdi[i]};
          if (nrise[i] == 0) first[i] <= cyc[i] + 1;
          nrise[i] <= nrise[i] + 1;
        end
      end
    end
  end

  // busy for u2: high for 30 cycles after every cnv rise
  initial begin
    int   bcnt;
    logic bprev;
    busy2 = 1'b0; bcnt = 0; bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        busy2 = 1'b0; bprev = 1'b0;
      end else begin
        if (cnv[2] && !bprev) begin
          busy2 = 1'b1; bcnt = 0;
        end else if (busy2) begin
          bcnt++;
          if (bcnt == 30) busy2 = 1'b0;
        end
        bprev = cnv[2];
      end
    end
  end

  task automatic wait_rec(input int i, input int n, input string name);
    int t;
    t = 0;
    while (nrec[i] < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk(name, 32'(nrec[i] >= n), 32'd1);
  endtask

  typedef struct {
    int   cyc;
    logic cnv;
    logic scki;
    logic sdi;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[16];
    logic [7:0]  exp0[9];
    logic [7:0]  exp1[4];
    int          base, t;
    int          busy_lat;

    vecs[0]  = '{0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{27, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{28, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{29, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{30, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{31, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{38, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{39, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{43, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{44, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{75, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{76, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{77, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{78, 1'b1, 1'b0, 1'b0};
    exp0 = '{8'h87, 8'h8F, 8'h97, 8'h9F, 8'hA7, 8'hAF, 8'hB7, 8'hBF, 8'h87};
    exp1 = '{8'h83, 8'h8B, 8'h93, 8'h83};
`ifdef LTC2333_WRITE_BUSY_SYNC_EN
    busy_lat = 34;
`else
    busy_lat = 33;
`endif

    aresetn = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); #1;
      chk("reset_outputs", {23'd0, cnv, scki, sdi}, 32'd0);
    end
    @(negedge clk); #5;
    aresetn = 1'b1;

    for (int n = 0; n <= 78; n++) begin
      @(negedge clk); #1;
      for (int v = 0; v < 16; v++)
        if (vecs[v].cyc == n)
          chk($sformatf("frame0_cycle%0d", n), {29'd0, cnv[0], scki[0], sdi[0]},
              {29'd0, vecs[v].cnv, vecs[v].scki, vecs[v].sdi});
    end

    wait_rec(0, 9, "u0_frames_collected");
    for (int f = 0; f < 9; f++) begin
      chk($sformatf("u0_word_f%0d", f), 32'(rec_word[0][f]), {8'd0, exp0[f], 16'd0});
      chk($sformatf("u0_rises_f%0d", f), 32'(rec_n[0][f]), 32'd24);
      chk($sformatf("u0_first_rise_f%0d", f), 32'(rec_first[0][f]), 32'd29);
      chk($sformatf("u0_period_f%0d", f), 32'(rec_per[0][f]), 32'd78);
    end

    wait_rec(1, 4, "u1_frames_collected");
    for (int f = 0; f < 4; f++)
      chk($sformatf("u1_word_f%0d", f), 32'(rec_word[1][f]), {8'd0, exp1[f], 16'd0});

    wait_rec(2, 2, "u2_frames_collected");
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("u2_word_f%0d", f), 32'(rec_word[2][f]), {8'd0, exp0[f], 16'd0});
      chk($sformatf("u2_busy_latency_f%0d", f), 32'(rec_first[2][f]), 32'(busy_lat));
      chk($sformatf("u2_rises_f%0d", f), 32'(rec_n[2][f]), 32'd24);
    end
    chk("u0_scki_during_cnv", 32'(viol[0]), 32'd0);
    chk("u2_scki_during_busy", 32'(viol[2]), 32'd0);

    // reset asserted in the middle of SHIFT (k=10)
    t = 0;
    do begin @(negedge clk); t++; end while (cnv[0] && t < 200);
    do begin @(negedge clk); t++; end while (!cnv[0] && t < 200);
    chk("u0_cnv_found", 32'(cnv[0]), 32'd1);
    repeat (38) @(negedge clk);
    #1;
    chk("u0_k10_before_reset", {30'd0, scki[0], sdi[0]}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("u0_async_reset_outputs", {29'd0, cnv[0], scki[0], sdi[0]}, 32'd0);
    @(negedge clk); #5;
    aresetn = 1'b1;
    base = nrec[0];
    wait_rec(0, base + 1, "u0_post_reset_frame");
    chk("u0_post_reset_word", 32'(rec_word[0][base]), 32'h00870000);
    chk("u0_post_reset_rises", 32'(rec_n[0][base]), 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
